// File: rtl/boundary_scroll_buffer.sv
// Scrolling row store for river boundaries: rows live in one synchronous RAM and a head
// pointer rotates on each committed scroll, so no row data ever moves.
`timescale 1ns / 1ps

module boundary_scroll_buffer #(
    parameter int unsigned DEPTH = 480,
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic [WIDTH-1:0] datain,
    input  logic             vblank,
    input  logic [8:0]       readaddress,
    output logic [WIDTH-1:0] dataout,
    output logic             busy,
    output logic             pending,
    output logic             overrun
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        StClear,
        StRun
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    clr_addr_q, clr_addr_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    head_dec;
    logic             shift_q;
    logic             shift_edge;
    logic [WIDTH-1:0] staging_q, staging_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] dataout_q;

    logic             commit;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             rd_oob;
    int unsigned      rd_sum;
    int unsigned      rd_wrap;
    logic [AW-1:0]    rd_phys;

    assign shift_edge = shift & ~shift_q;
    assign head_dec   = (head_q == '0) ? AW'(DEPTH - 1) : head_q - 1'b1;

    // Read path always uses the current (pre-commit) head.
    always_comb begin
        rd_oob  = 32'(readaddress) >= DEPTH;
        rd_sum  = 32'(head_q) + 32'(readaddress);
        rd_wrap = (rd_sum >= DEPTH) ? rd_sum - DEPTH : rd_sum;
        rd_phys = rd_oob ? '0 : AW'(rd_wrap);
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        head_d     = head_q;
        staging_d  = staging_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        commit     = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;

        case (state_q)
            StClear: begin
                we    = 1'b1;
                waddr = clr_addr_q;
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    clr_addr_d = '0;
                    state_d    = StRun;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            StRun: begin
                if (pending_q && vblank) begin
                    commit = 1'b1;
                    head_d = head_dec;
                    we     = 1'b1;
                    waddr  = head_dec;
                    wdata  = staging_q;
                end
            end
        endcase

        // A capture coinciding with a commit is not an overrun: the commit drains the old row.
        if (shift_edge) begin
            staging_d = datain;
            pending_d = 1'b1;
            if (pending_q && !commit) begin
                overrun_d = 1'b1;
            end
        end else if (commit) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            head_q     <= '0;
            shift_q    <= 1'b0;
            staging_q  <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            head_q     <= head_d;
            shift_q    <= shift;
            staging_q  <= staging_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dataout_q <= '0;
        end else if (busy || rd_oob) begin
            dataout_q <= '0;
        end else begin
            dataout_q <= mem[rd_phys];
        end
    end

    assign busy    = (state_q == StClear);
    assign pending = pending_q;
    assign overrun = overrun_q;
    assign dataout = dataout_q;

endmodule

// File: tb/tb_boundary_scroll_buffer.sv
// Directed bench for boundary_scroll_buffer: a shifting-array model predicts every row read.
`timescale 1ns / 1ps

module tb_boundary_scroll_buffer;

    localparam int unsigned DEPTH = 480;
    localparam int unsigned WIDTH = 40;

    logic             clk;
    logic             reset;
    logic             shift;
    logic [WIDTH-1:0] datain;
    logic             vblank;
    logic [8:0]       readaddress;
    logic [WIDTH-1:0] dataout;
    logic             busy;
    logic             pending;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    boundary_scroll_buffer #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .shift      (shift),
        .datain     (datain),
        .vblank     (vblank),
        .readaddress(readaddress),
        .dataout    (dataout),
        .busy       (busy),
        .pending    (pending),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic model_commit(input logic [WIDTH-1:0] d);
        for (int i = DEPTH - 1; i > 0; i--) model[i] = model[i-1];
        model[0] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Busy must last exactly DEPTH cycles after release; reads meanwhile return zero.
    task automatic wait_clear();
        int cnt = 0;
        while (busy === 1'b1 && cnt < 600) begin
            check("clear_dataout", 64'(dataout), 64'h0);
            readaddress = 9'(cnt % DEPTH);
            cnt++;
            step();
        end
        check("busy_cycles", 64'(cnt), 64'd480);
        readaddress = '0;
    endtask

    task automatic read_row(input int addr, input string tag);
        exp_q.push_back((addr < DEPTH) ? model[addr] : '0);
        readaddress = 9'(addr);
        step();
        check(tag, 64'(dataout), 64'(exp_q.pop_front()));
    endtask

    task automatic capture(input logic [WIDTH-1:0] d);
        datain = d;
        shift  = 1'b1;
        step();
        shift  = 1'b0;
        step();
    endtask

    task automatic push_row(input logic [WIDTH-1:0] d);
        capture(d);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        model_commit(d);
    endtask

    initial begin
        reset       = 1'b0;
        shift       = 1'b0;
        vblank      = 1'b0;
        datain      = '0;
        readaddress = '0;
        model_clear();
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'h1);
        check("rst_pending", 64'(pending), 64'h0);
        check("rst_overrun", 64'(overrun), 64'h0);
        check("rst_dataout", 64'(dataout), 64'h0);
        reset = 1'b1;
        wait_clear();
        check("run_busy", 64'(busy), 64'h0);

        // Single capture held off by vblank for 100 cycles.
        capture(40'h0A_0C8_3C_0F0);
        repeat (100) step();
        check("hold_pending", 64'(pending), 64'h1);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        check("commit_pending", 64'(pending), 64'h0);
        model_commit(40'h0A_0C8_3C_0F0);
        read_row(0, "first_row0");

        // A, B, C commits.
        push_row(40'hAA_AAAA_0001);
        push_row(40'hBB_BBBB_0002);
        push_row(40'hCC_CCCC_0003);
        read_row(0, "abc_row0");
        read_row(1, "abc_row1");
        read_row(2, "abc_row2");
        read_row(3, "abc_row3");
        read_row(4, "abc_row4");

        // Read in the same cycle as a commit sees pre-commit data.
        capture(40'h11_2233_4455);
        exp_q.push_back(model[0]);
        readaddress = 9'd0;
        vblank      = 1'b1;
        step();
        vblank      = 1'b0;
        check("rdcommit_row0", 64'(dataout), 64'(exp_q.pop_front()));
        model_commit(40'h11_2233_4455);
        read_row(0, "rdcommit_after");

        // Edge coinciding with commit: old staging commits, new stays pending, no overrun.
        capture(40'hE1_0000_00E1);
        datain = 40'hE2_0000_00E2;
        shift  = 1'b1;
        vblank = 1'b1;
        step();
        shift  = 1'b0;
        vblank = 1'b0;
        model_commit(40'hE1_0000_00E1);
        check("coinc_pending", 64'(pending), 64'h1);
        check("coinc_overrun", 64'(overrun), 64'h0);
        step();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        model_commit(40'hE2_0000_00E2);
        read_row(0, "coinc_row0");
        read_row(1, "coinc_row1");

        // Overrun: two edges without a commit.
        capture(40'hD1_D1D1_D1D1);
        capture(40'hD2_D2D2_D2D2);
        check("ovr_overrun", 64'(overrun), 64'h1);
        check("ovr_pending", 64'(pending), 64'h1);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        model_commit(40'hD2_D2D2_D2D2);
        read_row(0, "ovr_row0");
        read_row(1, "ovr_row1");
        read_row(2, "ovr_row2");
        check("ovr_sticky", 64'(overrun), 64'h1);

        // Out-of-range reads.
        read_row(480, "oob_480");
        read_row(511, "oob_511");

        // 481 commits wrap the head all the way round.
        for (int i = 0; i < 481; i++) push_row(40'hA5_0000_0000 | 40'(i));
        read_row(0, "wrap_row0");
        read_row(1, "wrap_row1");
        read_row(240, "wrap_row240");
        read_row(479, "wrap_row479");
        check("wrap_479_second", 64'(model[479]), 64'hA5_0000_0001);

        // Reset in the middle of a commit.
        capture(40'h77_7777_7777);
        vblank = 1'b1;
        reset  = 1'b0;
        step();
        vblank = 1'b0;
        check("rstc_busy", 64'(busy), 64'h1);
        check("rstc_pending", 64'(pending), 64'h0);
        check("rstc_overrun", 64'(overrun), 64'h0);
        check("rstc_dataout", 64'(dataout), 64'h0);
        step();
        reset = 1'b1;
        model_clear();
        wait_clear();
        read_row(0, "rstc_row0");
        read_row(479, "rstc_row479");
        push_row(40'h12_3456_789A);
        read_row(0, "rstc_new0");
        read_row(1, "rstc_new1");

        // Shift held across reset release: one edge, commit waits for RUN.
        reset  = 1'b0;
        shift  = 1'b1;
        datain = 40'hF0_0F0F_F00F;
        vblank = 1'b1;
        repeat (2) step();
        reset  = 1'b1;
        model_clear();
        wait_clear();
        check("held_pending", 64'(pending), 64'h1);
        check("held_overrun", 64'(overrun), 64'h0);
        step();
        vblank = 1'b0;
        shift  = 1'b0;
        check("held_commit", 64'(pending), 64'h0);
        model_commit(40'hF0_0F0F_F00F);
        read_row(0, "held_row0");
        read_row(1, "held_row1");
        check("held_no_ovr", 64'(overrun), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boundary_scroll_buffer.md
BOUNDARY_SCROLL_BUFFER -- requirements
Module: boundary_scroll_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 480, meaning number of stored screen rows.
REQ-002 SHALL have parameter WIDTH, default 40, meaning bits per row (four 10-bit river boundaries).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port shift  input  1  level from host register; each rising edge requests one scroll.
REQ-006 SHALL have port datain  input  WIDTH  new top row, captured on the shift rising edge.
REQ-007 SHALL have port vblank  input  1  high while the display is outside the active rows; commits allowed only then.
REQ-008 SHALL have port readaddress  input  9  logical row (0 = top of screen) requested by the display stage.
REQ-009 SHALL have port dataout  output  WIDTH  registered row data for readaddress.
REQ-010 SHALL have port busy  output  1  high while post-reset clearing runs.
REQ-011 SHALL have port pending  output  1  a captured row is waiting for commit.
REQ-012 SHALL have port overrun  output  1  sticky; a capture replaced an uncommitted row.

Function
REQ-013 SHALL store DEPTH x WIDTH rows in one synchronous RAM plus a head pointer (0..DEPTH-1); no physical data movement on scroll.
REQ-014 SHALL map logical row r to physical address (head + r) mod DEPTH, computed as sum minus DEPTH when sum >= DEPTH (sum max 2*DEPTH-2).
REQ-015 SHALL register dataout with 1-cycle latency: readaddress sampled at edge N, data valid after edge N+1.
REQ-016 SHALL drive dataout = 0 when readaddress >= DEPTH or busy = 1.
REQ-017 SHALL detect shift rising edge as shift & ~shift_q, with shift_q a 1-cycle delayed copy.
REQ-018 SHALL, on an edge, load datain into a staging register and set pending.
REQ-019 SHALL run a two-state FSM: CLEAR and RUN.
REQ-020 In CLEAR SHALL write zero to one physical address per cycle, 0 to DEPTH-1, then enter RUN; busy = 1 exactly in CLEAR (DEPTH cycles).
REQ-021 In RUN, when pending && vblank, SHALL commit in one cycle: head <= (head == 0) ? DEPTH-1 : head-1; staging written to that new physical address; pending cleared.
REQ-022 After a commit, logical row 0 SHALL be the new row, and old logical row r SHALL become row r+1; old row DEPTH-1 is discarded.
REQ-023 SHALL perform at most one commit per cycle; a shift edge with pending already set SHALL overwrite staging, keep pending = 1, and set overrun.
REQ-024 An edge in the same cycle as a commit SHALL let the commit use the old staging value; the new data is captured and pending stays 1; overrun is not set.
REQ-025 Edges during CLEAR SHALL be captured normally; commit SHALL wait for RUN and vblank.
REQ-026 A read in the same cycle as a commit SHALL use the pre-commit head and return pre-commit RAM contents.
REQ-027 Overrun SHALL clear only on reset.

Reset
REQ-028 While reset = 0 at a clk edge, the block SHALL set state = CLEAR, clear address = 0, head = 0, shift_q = 0, staging = 0, pending = 0, overrun = 0 and dataout = 0.
REQ-029 Reset asserted mid-CLEAR or mid-commit SHALL abandon the operation and restart CLEAR from address 0 after release.
REQ-030 A shift held high across reset release SHALL produce exactly one edge on the first cycle out of reset.

Verification
REQ-031 Release reset, readaddress sweeps 0..479 -> busy high exactly 480 cycles; all dataout = 0; then busy low.
REQ-032 In RUN, datain = 40'h0A_0C8_3C_0F0, shift 0->1, vblank = 0 for 100 cycles then 1 -> pending = 1 until the first vblank cycle; next cycle readaddress 0 returns 40'h0A_0C8_3C_0F0.
REQ-033 Commit rows A, B, C in order (one per vblank) -> logical rows 0, 1, 2 read C, B, A; row 3 reads 0.
REQ-034 Do 481 commits -> head wraps 0 -> 479 -> ... with no glitch; row 479 holds the 2nd-committed value; row 0 holds the latest.
REQ-035 Two shift edges (data D1, D2) with vblank = 0 -> overrun = 1, pending = 1; after vblank, row 0 = D2 and row 1 is unchanged.
REQ-036 readaddress = 480 or 511 -> dataout = 0 one cycle later; reset pulse during commit -> CLEAR restarts, head = 0.
